debug_host_link: RTL
====================

Name: debug_host_link

Overview:
- Hardware host for the MIPS debug unit's UART protocol: plays the PC side of the link.
- Loads a program from a local instruction ROM into the debug unit and issues run/step commands.
- Receives and reassembles the returned debug frame into 32-bit words.
- Sits between a UART tx/rx pair and a bench/top-level controller; used for self-test without a PC.

Parameters:
len, 32, word width of instructions and frame words
LEN_DATA, 8, UART byte width
cant_instrucciones, 64, ROM depth; max program length
cant_regs, 32, register words per frame
cant_mem_datos, 16, data-memory words per frame
nb_header_words, 6, header words per frame (pc, four latches, cycle count)
RX_TIMEOUT, 1000000, clk cycles allowed between received bytes before abort

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  pulse: begin programming from ROM address 0
mode_step  input  1  sampled with run: 0 = continuous, 1 = step-by-step
run  input  1  pulse: issue run command (valid in READY)
step_req  input  1  pulse: request one step (valid in STEP_WAIT)
step_exit  input  1  pulse: leave step mode, return to READY
reprogram  input  1  pulse: send reprogram command, then reload ROM
prog_addr  output  $clog2(cant_instrucciones)  ROM read address
prog_data  input  len  ROM data; 1-cycle read latency
tx_start  output  1  one-cycle pulse: UART transmit tx_data
tx_data  output  LEN_DATA  byte to transmit; held stable until tx_done
tx_done  input  1  UART transmit complete pulse
rx_done  input  1  UART byte received pulse
rx_data  input  LEN_DATA  received byte; valid when rx_done
word_out  output  len  reassembled frame word
word_idx  output  6  index of word_out within frame (0..53 at defaults)
word_valid  output  1  one-cycle pulse: word_out/word_idx valid
frame_done  output  1  one-cycle pulse after last frame word
busy  output  1  high in every state except IDLE, READY, STEP_WAIT
error  output  2  sticky: bit0 = program overflow, bit1 = rx timeout; cleared by start
state_out  output  4  current state encoding

Behaviour:
- Command bytes: Start 0x01, Continuous 0x02, StepByStep 0x03, ReProgram 0x05, Step 0x06.
- Reset values: all outputs 0, state IDLE, prog_addr 0, error 0.
- Byte send:
  - tx_data is set and tx_start pulses for 1 cycle.
  - The FSM waits for tx_done before the next byte; tx_data is held throughout.
  - tx_done outside a wait is ignored.
- States and transitions:
  - IDLE: on start -> SEND_START (byte 0x01); prog_addr = 0; error cleared.
  - FETCH: present prog_addr and wait 1 cycle, then latch prog_data into the instruction register.
  - SEND_INS: send 4 bytes, LSB first ([7:0], [15:8], [23:16], [31:24]).
  - CHECK:
    - instr[31:26] == 6'b111111 -> READY.
    - Else, if prog_addr == cant_instrucciones-1 -> set error[0] -> READY.
    - Else prog_addr + 1 -> FETCH.
  - READY:
    - Priority reprogram > run.
    - reprogram: send 0x05 -> SEND_START.
    - run: send 0x02 or 0x03 (per mode_step) -> RECV if continuous, STEP_WAIT if step.
  - STEP_WAIT:
    - step_exit has priority over step_req; step_exit -> READY.
    - step_req: send 0x06 -> RECV.
  - RECV:
    - Each rx_done shifts rx_data into byte lane cnt[1:0], LSB first.
    - The cycle after the 4th byte: word_valid = 1 and word_idx increments.
    - After word nb_header_words+cant_regs+cant_mem_datos-1, frame_done pulses the same cycle as the last word_valid.
    - Exit: -> STEP_WAIT if the run was step mode, else -> READY.
- Timeout: in RECV, an idle counter resets on each rx_done. When it reaches RX_TIMEOUT: set error[1], discard the partial word, do not pulse frame_done, go to READY.
- rx_done outside RECV is ignored. start, run and step_req in busy states are ignored.
- Reset asserted mid-operation: immediate return to reset values; any partial frame is discarded.

Test Plan:
- 3-word ROM {0x20010005, 0x20020003, 0xFC000000} + start -> tx bytes 01,05,00,01,20,03,00,02,20,00,00,00,FC; then READY, error=0.
- ROM with no halt opcode, 64 words -> 1+256 bytes sent; error[0]=1; prog_addr stops at 63.
- READY, run with mode_step=0 -> tx 0x02; feed 216 bytes, byte k = k mod 256 -> 54 word_valid pulses, word 0 = 0x03020100, word 53 = 0xD7D6D5D4; frame_done with word 53; state READY.
- Step mode: run (tx 0x03) -> STEP_WAIT; step_req -> tx 0x06; full frame -> back to STEP_WAIT; step_exit -> READY.
- RECV, feed 10 bytes then silence for RX_TIMEOUT cycles -> error=2'b10, READY; 2 word_valid pulses, no frame_done.
- Reset low mid SEND_INS, after 2 of 4 bytes -> outputs zero, IDLE; new start resends 0x01 from address 0.

Source files
------------

// File: rtl/debug_host_link.sv
// debug_host_link: hardware stand-in for the PC side of the MIPS debug-unit UART link.
// It streams a program from a local ROM to the debug unit, then issues run, step and
// reprogram commands. It also reassembles the returned debug frame into 32-bit words.
// Ports:
//   clk, reset (async, active-low)
//   start/mode_step/run/step_req/step_exit/reprogram : controller requests (pulses)
//   prog_addr/prog_data : instruction ROM interface (1-cycle read latency)
//   tx_start/tx_data/tx_done : UART transmitter handshake
//   rx_done/rx_data : UART receiver byte strobe
//   word_out/word_idx/word_valid/frame_done : reassembled frame stream
//   busy, error (sticky: bit0 program overflow, bit1 rx timeout), state_out
module debug_host_link #(
  parameter int unsigned len                = 32,
  parameter int unsigned LEN_DATA           = 8,
  parameter int unsigned cant_instrucciones = 64,
  parameter int unsigned cant_regs          = 32,
  parameter int unsigned cant_mem_datos     = 16,
  parameter int unsigned nb_header_words    = 6,
  parameter int unsigned RX_TIMEOUT         = 1000000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  mode_step,
  input  logic                                  run,
  input  logic                                  step_req,
  input  logic                                  step_exit,
  input  logic                                  reprogram,
  output logic [$clog2(cant_instrucciones)-1:0] prog_addr,
  input  logic [len-1:0]                        prog_data,
  output logic                                  tx_start,
  output logic [LEN_DATA-1:0]                   tx_data,
  input  logic                                  tx_done,
  input  logic                                  rx_done,
  input  logic [LEN_DATA-1:0]                   rx_data,
  output logic [len-1:0]                        word_out,
  output logic [5:0]                            word_idx,
  output logic                                  word_valid,
  output logic                                  frame_done,
  output logic                                  busy,
  output logic [1:0]                            error,
  output logic [3:0]                            state_out
);

  localparam int unsigned AW       = $clog2(cant_instrucciones);
  localparam int unsigned BPW      = len / LEN_DATA;
  localparam int unsigned CW       = $clog2(BPW);
  localparam int unsigned TW       = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned NB_WORDS = nb_header_words + cant_regs + cant_mem_datos;

  localparam logic [LEN_DATA-1:0] CMD_START   = LEN_DATA'(8'h01);
  localparam logic [LEN_DATA-1:0] CMD_CONT    = LEN_DATA'(8'h02);
  localparam logic [LEN_DATA-1:0] CMD_STEPMOD = LEN_DATA'(8'h03);
  localparam logic [LEN_DATA-1:0] CMD_REPROG  = LEN_DATA'(8'h05);
  localparam logic [LEN_DATA-1:0] CMD_STEP    = LEN_DATA'(8'h06);

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    SEND_START  = 4'd1,
    FETCH       = 4'd2,
    SEND_INS    = 4'd3,
    CHECK       = 4'd4,
    READY       = 4'd5,
    SEND_REPROG = 4'd6,
    SEND_RUN    = 4'd7,
    STEP_WAIT   = 4'd8,
    SEND_STEP   = 4'd9,
    RECV        = 4'd10
  } state_t;

  state_t            state, state_n;
  logic [AW-1:0]     prog_addr_n;
  logic [len-1:0]    instr, instr_n;
  logic [CW-1:0]     ins_cnt, ins_cnt_n;
  logic              tx_wait, tx_wait_n;
  logic              fetch_wait, fetch_wait_n;
  logic              step_mode, step_mode_n;
  logic [CW-1:0]     rx_cnt, rx_cnt_n;
  logic [len-1:0]    word_buf, word_buf_n;
  logic [5:0]        wcnt, wcnt_n;
  logic [TW-1:0]     idle_cnt, idle_cnt_n;
  logic              tx_start_n;
  logic [LEN_DATA-1:0] tx_data_n;
  logic [len-1:0]    word_out_n;
  logic [5:0]        word_idx_n;
  logic              word_valid_n, frame_done_n, busy_n;
  logic [1:0]        error_n;

  assign state_out = state;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      prog_addr  <= '0;
      instr      <= '0;
      ins_cnt    <= '0;
      tx_wait    <= 1'b0;
      fetch_wait <= 1'b0;
      step_mode  <= 1'b0;
      rx_cnt     <= '0;
      word_buf   <= '0;
      wcnt       <= '0;
      idle_cnt   <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      word_out   <= '0;
      word_idx   <= '0;
      word_valid <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      error      <= '0;
    end else begin
      state      <= state_n;
      prog_addr  <= prog_addr_n;
      instr      <= instr_n;
      ins_cnt    <= ins_cnt_n;
      tx_wait    <= tx_wait_n;
      fetch_wait <= fetch_wait_n;
      step_mode  <= step_mode_n;
      rx_cnt     <= rx_cnt_n;
      word_buf   <= word_buf_n;
      wcnt       <= wcnt_n;
      idle_cnt   <= idle_cnt_n;
      tx_start   <= tx_start_n;
      tx_data    <= tx_data_n;
      word_out   <= word_out_n;
      word_idx   <= word_idx_n;
      word_valid <= word_valid_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
      error      <= error_n;
    end
  end

  // Next-state and output logic. Every send state issues one tx_start,
  // then holds tx_data until the UART reports tx_done.
  always_comb begin
    state_n      = state;
    prog_addr_n  = prog_addr;
    instr_n      = instr;
    ins_cnt_n    = ins_cnt;
    tx_wait_n    = tx_wait;
    fetch_wait_n = fetch_wait;
    step_mode_n  = step_mode;
    rx_cnt_n     = rx_cnt;
    word_buf_n   = word_buf;
    wcnt_n       = wcnt;
    idle_cnt_n   = idle_cnt;
    tx_start_n   = 1'b0;
    tx_data_n    = tx_data;
    word_out_n   = word_out;
    word_idx_n   = word_idx;
    word_valid_n = 1'b0;
    frame_done_n = 1'b0;
    error_n      = error;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_n     = SEND_START;
          prog_addr_n = '0;
          error_n     = '0;
          tx_wait_n   = 1'b0;
        end
      end

      SEND_START: begin
        if (!tx_wait) begin
          tx_start_n = 1'b1;
          tx_data_n  = CMD_START;
          tx_wait_n  = 1'b1;
        end else if (tx_done) begin
          tx_wait_n    = 1'b0;
          fetch_wait_n = 1'b0;
          state_n      = FETCH;
        end
      end

      // First cycle lets the ROM register the address; second latches the data.
      FETCH: begin
        if (!fetch_wait) begin
          fetch_wait_n = 1'b1;
        end else begin
          instr_n   = prog_data;
          ins_cnt_n = '0;
          tx_wait_n = 1'b0;
          state_n   = SEND_INS;
        end
      end

      SEND_INS: begin
        if (!tx_wait) begin
          tx_start_n = 1'b1;
          tx_data_n  = instr[ins_cnt*LEN_DATA +: LEN_DATA];
          tx_wait_n  = 1'b1;
        end else if (tx_done) begin
          tx_wait_n = 1'b0;
          if (ins_cnt == CW'(BPW - 1)) begin
            state_n = CHECK;
          end else begin
            ins_cnt_n = ins_cnt + CW'(1);
          end
        end
      end

      // Halt opcode ends the program; running off the ROM end flags overflow.
      CHECK: begin
        if (instr[len-1 -: 6] == 6'h3F) begin
          state_n = READY;
        end else if (prog_addr == AW'(cant_instrucciones - 1)) begin
          error_n[0] = 1'b1;
          state_n    = READY;
        end else begin
          prog_addr_n  = prog_addr + AW'(1);
          fetch_wait_n = 1'b0;
          state_n      = FETCH;
        end
      end

      READY: begin
        tx_wait_n = 1'b0;
        if (reprogram) begin
          state_n = SEND_REPROG;
        end else if (run) begin
          step_mode_n = mode_step;
          state_n     = SEND_RUN;
        end
      end

      SEND_REPROG: begin
        if (!tx_wait) begin
          tx_start_n = 1'b1;
          tx_data_n  = CMD_REPROG;
          tx_wait_n  = 1'b1;
        end else if (tx_done) begin
          tx_wait_n   = 1'b0;
          prog_addr_n = '0;
          state_n     = SEND_START;
        end
      end

      SEND_RUN: begin
        if (!tx_wait) begin
          tx_start_n = 1'b1;
          tx_data_n  = step_mode ? CMD_STEPMOD : CMD_CONT;
          tx_wait_n  = 1'b1;
        end else if (tx_done) begin
          tx_wait_n = 1'b0;
          if (step_mode) begin
            state_n = STEP_WAIT;
          end else begin
            rx_cnt_n   = '0;
            wcnt_n     = '0;
            idle_cnt_n = '0;
            state_n    = RECV;
          end
        end
      end

      STEP_WAIT: begin
        tx_wait_n = 1'b0;
        if (step_exit) begin
          state_n = READY;
        end else if (step_req) begin
          state_n = SEND_STEP;
        end
      end

      SEND_STEP: begin
        if (!tx_wait) begin
          tx_start_n = 1'b1;
          tx_data_n  = CMD_STEP;
          tx_wait_n  = 1'b1;
        end else if (tx_done) begin
          tx_wait_n  = 1'b0;
          rx_cnt_n   = '0;
          wcnt_n     = '0;
          idle_cnt_n = '0;
          state_n    = RECV;
        end
      end

      // Bytes arrive LSB first; a completed word is presented the next cycle.
      RECV: begin
        if (rx_done) begin
          idle_cnt_n = '0;
          word_buf_n[rx_cnt*LEN_DATA +: LEN_DATA] = rx_data;
          rx_cnt_n = rx_cnt + CW'(1);
          if (rx_cnt == CW'(BPW - 1)) begin
            word_out_n   = word_buf_n;
            word_idx_n   = wcnt;
            word_valid_n = 1'b1;
            wcnt_n       = wcnt + 6'd1;
            if (wcnt == 6'(NB_WORDS - 1)) begin
              frame_done_n = 1'b1;
              state_n      = step_mode ? STEP_WAIT : READY;
            end
          end
        end else if (idle_cnt == TW'(RX_TIMEOUT - 1)) begin
          error_n[1] = 1'b1;
          rx_cnt_n   = '0;
          state_n    = READY;
        end else begin
          idle_cnt_n = idle_cnt + TW'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE) && (state_n != READY) && (state_n != STEP_WAIT);
  end

endmodule
